// File: rtl/bounded_wrap_counter.sv
// Bounded counter c stepping toward a fixed bound n, rewinding to 1 at the bound.
// Optional simulation checker enabled by defining INVARIANT_CHECK_EN.

module bounded_wrap_counter #(
  parameter int WIDTH  = 11,
  parameter int N_INIT = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             selector,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] n
);

  if ((N_INIT < 1) || (N_INIT > ((2 ** WIDTH) - 1))) begin : g_bad_n_init
    $error("bounded_wrap_counter: N_INIT must lie in 1..2^WIDTH-1");
  end

  logic [WIDTH-1:0] c_r;
  logic [WIDTH-1:0] n_r;
  logic [WIDTH-1:0] c_next_s;

  // Next counter value: step until the bound, rewind only from the bound.
  always_comb begin
    c_next_s = c_r;
    if (selector) begin
      if (c_r != n_r) begin
        c_next_s = c_r + WIDTH'(1);
      end else begin
        c_next_s = c_r;
      end
    end else begin
      if (c_r == n_r) begin
        c_next_s = WIDTH'(1);
      end else begin
        c_next_s = c_r;
      end
    end
  end

  // State registers; reset has priority over selector.
  always_ff @(posedge clk) begin
    if (rst) begin
      c_r <= '0;
      n_r <= WIDTH'(N_INIT);
    end else begin
      c_r <= c_next_s;
      n_r <= n_r;
    end
  end

  assign c = c_r;
  assign n = n_r;

`ifdef INVARIANT_CHECK_EN
  bounded_wrap_counter_chk #(
    .WIDTH  (WIDTH),
    .N_INIT (N_INIT)
  ) u_chk (
    .clk      (clk),
    .rst      (rst),
    .selector (selector),
    .c        (c_r),
    .n        (n_r)
  );
`endif

endmodule

`ifdef INVARIANT_CHECK_EN
// Simulation-only invariant checker and rewind-event counter.
module bounded_wrap_counter_chk #(
  parameter int WIDTH  = 11,
  parameter int N_INIT = 10
) (
  input logic             clk,
  input logic             rst,
  input logic             selector,
  input logic [WIDTH-1:0] c,
  input logic [WIDTH-1:0] n
);

  logic [31:0] rewind_count_r;

  // Invariant 0 <= c <= n with a constant, nonzero bound.
  always @(posedge clk) begin
    if (!rst) begin
      if (!((c <= n) && (n > WIDTH'(0)) && (n == WIDTH'(N_INIT)))) begin
        $fatal(1, "bounded_wrap_counter invariant violated at %0t: c=%0d n=%0d", $time, c, n);
      end
    end
  end

  // Counts accepted rewinds since the last reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      rewind_count_r <= 32'd0;
    end else if (!selector && (c == n)) begin
      rewind_count_r <= rewind_count_r + 32'd1;
    end else begin
      rewind_count_r <= rewind_count_r;
    end
  end

endmodule
`endif

// File: tb/tb_bounded_wrap_counter.sv
// Self-checking bench for bounded_wrap_counter: directed plan plus random soak
// against an arithmetic reference model.

module tb_bounded_wrap_counter;

  localparam int WIDTH  = 11;
  localparam int N_INIT = 10;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             selector = 1'b0;
  logic [WIDTH-1:0] c;
  logic [WIDTH-1:0] n;

  int tests_run = 0;
  int tests_failed = 0;
  int model_c = 0;
  int model_n = N_INIT;
  int model_rewinds = 0;

  bounded_wrap_counter #(
    .WIDTH  (WIDTH),
    .N_INIT (N_INIT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .selector (selector),
    .c        (c),
    .n        (n)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int observed, input int expected);
    tests_run++;
    if (observed != expected) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, observed, expected, $time);
    end
  endtask

  // Apply inputs for one edge, advance the reference model, compare c and n.
  task automatic tick(input logic r, input logic sel);
    rst = r;
    selector = sel;
    @(posedge clk);
    #1;
    if (r) begin
      model_c = 0;
      model_n = N_INIT;
      model_rewinds = 0;
    end else if (sel) begin
      if (model_c < model_n) model_c = model_c + 1;
    end else begin
      if (model_c == model_n) begin
        model_c = 1;
        model_rewinds = model_rewinds + 1;
      end
    end
    check_val("c_model", int'(c), model_c);
    check_val("n_model", int'(n), model_n);
  endtask

  initial begin
    #1;
    // Reset, then rewind with c=0 holds.
    tick(1'b1, 1'b0);
    check_val("reset_c", int'(c), 0);
    check_val("reset_n", int'(n), 10);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    check_val("hold_zero", int'(c), 0);

    // Step to bound: 1..10 then hold.
    for (int i = 1; i <= 12; i++) begin
      tick(1'b0, 1'b1);
      check_val("step", int'(c), (i <= 10) ? i : 10);
    end

    // Rewind at bound, then rewind at c=1 holds.
    tick(1'b0, 1'b0);
    check_val("rewind", int'(c), 1);
    tick(1'b0, 1'b0);
    check_val("rewind_hold", int'(c), 1);

    // Climb to 5, rewind blocked, then climb to bound.
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b1);
    check_val("at_five", int'(c), 5);
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0);
    check_val("rewind_blocked", int'(c), 5);
    for (int i = 0; i < 5; i++) tick(1'b0, 1'b1);
    check_val("back_to_bound", int'(c), 10);

    // Reset priority at c=7.
    tick(1'b0, 1'b0);
    for (int i = 0; i < 6; i++) tick(1'b0, 1'b1);
    check_val("at_seven", int'(c), 7);
    tick(1'b1, 1'b1);
    check_val("rst_prio_c", int'(c), 0);
    check_val("rst_prio_n", int'(n), 10);
    tick(1'b0, 1'b1);
    check_val("resume", int'(c), 1);

    // Random soak, biased toward stepping so the bound is reached often.
    tick(1'b1, 1'b0);
    for (int i = 0; i < 1000; i++) begin
      tick(1'b0, ($urandom_range(0, 99) < 65) ? 1'b1 : 1'b0);
      check_val("soak_range", (int'(c) <= 10) ? 1 : 0, 1);
    end
`ifdef INVARIANT_CHECK_EN
    check_val("rewind_count", int'(dut.u_chk.rewind_count_r), model_rewinds);
`endif

    // Random soak with sporadic mid-count resets.
    for (int i = 0; i < 300; i++) begin
      tick(($urandom_range(0, 99) < 5) ? 1'b1 : 1'b0, $urandom_range(0, 1) == 1 ? 1'b1 : 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
